// File: rtl/hazard_ctl_pkg.sv
// Shared codes and compare helpers for the pipeline hazard/forwarding controller.
package hazard_ctl_pkg;

  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC  = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Codes 5-7 are reserved and behave as no-write.
  function automatic logic res_wr(input logic [2:0] res);
    return (res != RES_NW) && (res <= RES_MD);
  endfunction

  function automatic logic [1:0] tnew_e(input logic [2:0] res);
    logic [1:0] t;
    case (res)
      RES_ALU, RES_MD: t = 2'd1;
      RES_DM:          t = 2'd2;
      default:         t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_m(input logic [2:0] res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic reg_match(input logic [4:0] ra, input logic [4:0] wa,
                                     input logic [2:0] res);
    return (ra != 5'd0) && (ra == wa) && res_wr(res);
  endfunction

  function automatic logic data_hazard(input logic [4:0] ra, input logic [1:0] tuse,
                                       input logic [4:0] wae, input logic [2:0] rese,
                                       input logic [4:0] wam, input logic [2:0] resm);
    if (tuse == TUSE_NONE) return 1'b0;
    return (reg_match(ra, wae, rese) && (tnew_e(rese) > tuse)) ||
           (reg_match(ra, wam, resm) && (tnew_m(resm) > tuse));
  endfunction

  function automatic logic [1:0] fwd_sel_d(input logic [4:0] ra,
                                           input logic [4:0] wae, input logic [2:0] rese,
                                           input logic [4:0] wam, input logic [2:0] resm,
                                           input logic [4:0] waw, input logic [2:0] resw);
    if (reg_match(ra, wae, rese) && (rese == RES_PC)) return FWD_E;
    if (reg_match(ra, wam, resm) && (tnew_m(resm) == 2'd0)) return FWD_M;
    if (reg_match(ra, waw, resw)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] ra,
                                           input logic [4:0] wam, input logic [2:0] resm,
                                           input logic [4:0] waw, input logic [2:0] resw);
    if (reg_match(ra, wam, resm) && (tnew_m(resm) == 2'd0)) return FWD_M;
    if (reg_match(ra, waw, resw)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loads the unit latency on an accepted start, counts down to idle.
module md_busy_cnt #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic mdstartE,
  input  logic mddivE,
  output logic mdbusy
);

  localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A start while the unit is still busy is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == '0) begin
      if (mdstartE) cnt_d = mddivE ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
    end else begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign mdbusy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctl.sv
// Hazard and forwarding controller for the 5-stage pipeline: stalls, bubbles, forward selects,
// mult/div busy tracking and a saturating stall-cycle counter.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ra1D,
  input  logic [4:0]       ra2D,
  input  logic [1:0]       tuse1D,
  input  logic [1:0]       tuse2D,
  input  logic             mdD,
  input  logic [4:0]       ra1E,
  input  logic [4:0]       ra2E,
  input  logic [4:0]       waE,
  input  logic [2:0]       resE,
  input  logic             mdstartE,
  input  logic             mddivE,
  input  logic [4:0]       ra2M,
  input  logic [4:0]       waM,
  input  logic [2:0]       resM,
  input  logic [4:0]       waW,
  input  logic [2:0]       resW,
  input  logic             DEMWclr,
  output logic             stallD,
  output logic             Eclr,
  output logic [1:0]       fwdRsD,
  output logic [1:0]       fwdRtD,
  output logic [1:0]       fwdRsE,
  output logic [1:0]       fwdRtE,
  output logic             fwdRtM,
  output logic             mdbusy,
  output logic [CNT_W-1:0] stallcnt
);

  logic             data_stall;
  logic             md_stall;
  logic [CNT_W-1:0] stallcnt_q, stallcnt_d;

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk      (clk),
    .rst      (rst),
    .mdstartE (mdstartE),
    .mddivE   (mddivE),
    .mdbusy   (mdbusy)
  );

  always_comb begin
    data_stall = data_hazard(ra1D, tuse1D, waE, resE, waM, resM) |
                 data_hazard(ra2D, tuse2D, waE, resE, waM, resM);
    // The start cycle itself counts as busy for a waiting HI/LO access.
    md_stall   = mdD & (mdbusy | mdstartE);
    stallD     = (data_stall | md_stall) & ~DEMWclr;
    Eclr       = stallD | DEMWclr;

    fwdRsD = fwd_sel_d(ra1D, waE, resE, waM, resM, waW, resW);
    fwdRtD = fwd_sel_d(ra2D, waE, resE, waM, resM, waW, resW);
    fwdRsE = fwd_sel_e(ra1E, waM, resM, waW, resW);
    fwdRtE = fwd_sel_e(ra2E, waM, resM, waW, resW);
    fwdRtM = reg_match(ra2M, waW, resW);
  end

  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stallD && (stallcnt_q != '1)) stallcnt_d = stallcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stallcnt_q <= '0;
    else      stallcnt_q <= stallcnt_d;
  end

  assign stallcnt = stallcnt_q;

endmodule
